ifetch_npc_unit: RTL
====================

// Module: ifetch_npc_unit
// PURPOSE
//  Instruction-fetch stage upstream of the control decoder: holds PC, fetches from instruction
//  memory over a req/ack handshake, presents a stable instruction (opcode/funct to the decoder),
//  and on retirement computes next PC from the decoder's NPCop and the ALU zero flag.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC loaded on reset
//  EXC_VECTOR  32'h0000_4180  redirect target for a misaligned fetch (optional feature only)
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  hold         in   1   1 = do not start a new fetch while in IDLE
//  imem_req     out  1   fetch request, held until imem_ack
//  imem_addr    out  32  byte address of fetch (= pc)
//  imem_ack     in   1   instruction memory returns imem_rdata this cycle
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  latched instruction; stable while instr_valid
//  instr_valid  out  1   instr is valid for decode/execute
//  pc           out  32  address of instr
//  npc_op       in   2   00 seq, 01 jump, 10 branch-if-zero, 11 reserved
//  alu_zero     in   1   ALU zero flag for branch resolution
//  exec_done    in   1   current instruction retires this cycle
//  npc_err      out  1   1-cycle pulse: reserved npc_op seen at retire
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, npc_err=0.
//  rst dominates every other input; an imem_ack arriving in the cycle of or after reset is dropped.
//  FSM: IDLE -> REQ when hold=0. REQ: imem_req=1, imem_addr=pc; on imem_ack latch imem_rdata into
//   instr, set instr_valid, -> ISSUE (min latency: ack in first REQ cycle -> instr_valid next cycle).
//  ISSUE: instr_valid=1, instr/pc stable; exec_done=1 -> pc<=npc, instr_valid<=0, -> IDLE.
//   exec_done outside ISSUE is ignored. hold has no effect in REQ or ISSUE.
//  npc (mod 2^32, wraps silently): pc4 = pc+4 (0xFFFF_FFFC -> 0x0000_0000)
//   00: pc4; 01: {pc4[31:28], instr[25:0], 2'b00};
//   10: alu_zero ? pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}) : pc4; 11: pc4, npc_err pulses 1.
//  Back-to-back: exec_done -> IDLE -> REQ gives 1 idle cycle between instructions; no fetch overlap.
//  imem_ack while not in REQ is ignored; imem_rdata sampled only with imem_ack in REQ.
// CONFIGURATION
//  IFETCH_MISALIGN_TRAP_EN defined: in IDLE, if pc[1:0]!=0 no request is issued; pc<=EXC_VECTOR,
//   npc_err pulses 1, state stays IDLE (fetch proceeds next cycle from EXC_VECTOR).
//  Not defined: pc[1:0] ignored; imem_addr driven with pc unchanged, no trap.
// STRUCTURE
//  Shared package mips_pkg: NPC_SEQ=2'b00, NPC_JUMP=2'b01, NPC_BRANCH=2'b10, NPC_RSVD=2'b11;
//   fetch state enum {IDLE, REQ, ISSUE}; RESET_PC/EXC_VECTOR default constants.
//  One sub-module: npc_calc (combinational: pc, instr, npc_op, alu_zero -> npc, rsvd flag).
//  FSM, PC register and instr register stay in ifetch_npc_unit.
// TESTING
//  1 Reset then ack after 3 REQ cycles, rdata=32'h2401_0005 -> imem_addr=0x3000, instr latched,
//    instr_valid=1 one cycle after ack.
//  2 ISSUE, npc_op=01, instr=32'h0800_0C10, exec_done -> next imem_addr=0x0000_3040.
//  3 pc=0x3008, npc_op=10, instr[15:0]=16'hFFFE: alu_zero=1 -> 0x3004; alu_zero=0 -> 0x300C.
//  4 pc=0xFFFF_FFFC, npc_op=00, exec_done -> pc=0x0000_0000; npc_op=11 -> npc_err pulse, pc+4.
//  5 rst asserted mid-REQ with ack same cycle -> instr=0, instr_valid=0, pc=0x3000; hold=1 after
//    reset keeps imem_req=0 until hold=0.
//  6 With IFETCH_MISALIGN_TRAP_EN, branch to pc=0x3006 -> no req, npc_err=1, fetch from 0x4180;
//    without macro imem_addr=0x3006.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch/next-PC definitions: NPC opcodes, fetch FSM states and default addresses.
package mips_pkg;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_JUMP   = 2'b01;
  localparam logic [1:0] NPC_BRANCH = 2'b10;
  localparam logic [1:0] NPC_RSVD   = 2'b11;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_npc_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and instruction memory (slave).
// Handshake: the master raises imem_req with imem_addr stable and holds both until the
// cycle in which the slave raises imem_ack; imem_rdata is only meaningful in that cycle,
// and the transfer completes on that rising edge. imem_ack without imem_req is ignored.
interface ifetch_npc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_npc_unit_npc_calc.sv
// Combinational next-PC computation: sequential, jump, branch-if-zero, reserved flag.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic [1:0]  npc_op,
  input  logic        alu_zero,
  output logic [31:0] npc,
  output logic        rsvd
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  // Address arithmetic is modulo 2^32; overflow wraps without any flag.
  assign pc4    = pc + 32'd4;
  assign br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};

  // Select the next PC from the decoder's opcode; reserved falls back to pc+4.
  always_comb begin
    npc  = pc4;
    rsvd = 1'b0;
    case (npc_op)
      NPC_SEQ:    npc = pc4;
      NPC_JUMP:   npc = {pc4[31:28], instr_idx, 2'b00};
      NPC_BRANCH: npc = alu_zero ? (pc4 + br_off) : pc4;
      default: begin
        npc  = pc4;
        rsvd = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ifetch_npc_unit.sv
// Instruction fetch stage: PC register, fetch FSM (IDLE/REQ/ISSUE), latched instruction,
// next-PC update at retirement. Optional misaligned-fetch trap under IFETCH_MISALIGN_TRAP_EN.
module ifetch_npc_unit
  import mips_pkg::*;
#(
`ifdef IFETCH_MISALIGN_TRAP_EN
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
`endif
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  ifetch_npc_unit_if.master         imem,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  output logic [31:0]               pc,
  input  logic [1:0]                npc_op,
  input  logic                      alu_zero,
  input  logic                      exec_done,
  output logic                      npc_err,
  output fetch_state_t              dbg_state
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         err_q, err_d;
  logic [31:0]  npc;
  logic         rsvd;

  npc_calc u_npc_calc (
    .pc        (pc_q),
    .instr_idx (instr_q[25:0]),
    .npc_op    (npc_op),
    .alu_zero  (alu_zero),
    .npc       (npc),
    .rsvd      (rsvd)
  );

  // State, PC, instruction and error-pulse registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start fetch when not held, latch data on ack, update PC on retire.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (pc_q[1:0] != 2'b00) begin
          pc_d  = EXC_VECTOR;
          err_d = 1'b1;
        end else if (!hold) begin
          state_d = REQ;
        end
`else
        if (!hold) state_d = REQ;
`endif
      end
      REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          pc_d    = npc;
          err_d   = rsvd;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == ISSUE);
  assign pc             = pc_q;
  assign npc_err        = err_q;
  assign dbg_state      = state_q;

endmodule
